// File: rtl/rvfi_trace_pkg.sv
// Shared types and constants for the RVFI retirement trace buffer.
// Optional feature macro: RVFI_TRACE_TIMESTAMP_EN adds a capture-cycle
// timestamp field (ts) to every record.
package rvfi_trace_pkg;

    localparam int unsigned MODE_DROP      = 0;
    localparam int unsigned MODE_OVERWRITE = 1;

    // Width of the ts field; the module counter width TS_W must not exceed it.
    localparam int unsigned TRACE_TS_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } trace_state_t;

    typedef struct packed {
`ifdef RVFI_TRACE_TIMESTAMP_EN
        logic [TRACE_TS_W-1:0] ts;
`endif
        logic [31:0] insn;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
    } trace_rec_t;

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Record storage for the trace buffer: DEPTH-entry circular FIFO with
// wrap-bit pointers, registered occupancy and registered valid flag.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clear           synchronous flush, wins over wr_en/rd_en
//   wr_en, wr_data  write one record at the tail
//   rd_en           advance the head (caller guarantees non-empty)
//   head_c          head record, zero when empty
//   full_c          all entries occupied
//   level           registered occupancy
//   valid           registered level != 0
module rvfi_trace_fifo
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  trace_rec_t               wr_data,
    input  logic                     rd_en,
    output trace_rec_t               head_c,
    output logic                     full_c,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     valid
);

    localparam int unsigned AW = $clog2(DEPTH);

    trace_rec_t   mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  level_nxt;

    // Overwrite-on-full issues wr_en and rd_en together, leaving level unchanged.
    always_comb begin
        level_nxt = level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    // Same index, different wrap bit means the writer is a full lap ahead.
    assign full_c = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Gate with valid so stale storage never leaks onto the output.
    assign head_c = valid ? mem[rd_ptr[AW-1:0]] : '0;

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
            level <= level_nxt;
            valid <= (level_nxt != '0);
        end
    end

    // Storage array; contents need no reset since head_c is gated by valid.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: captures retired-instruction records while
// tracing is enabled and hands them to a ready/valid sink.
// Optional feature macro: RVFI_TRACE_TIMESTAMP_EN (TS_W-bit cycle timestamp).
// Ports:
//   CLK, RESET      clock and asynchronous active-high reset
//   rvfi_*          RVFI retirement interface (valid strobe and payload)
//   trace_en        capture enable (drives IDLE/RUN/DRAIN)
//   trace_clear     synchronous flush of FIFO, counters and FSM
//   out_valid/out_ready/out_record   head record handshake
//   level           occupancy, drop_cnt saturating drops, overflow sticky
module rvfi_trace_buffer
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned MODE  = MODE_DROP,
    parameter int unsigned TS_W  = TRACE_TS_W
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   rvfi_valid,
    input  logic [31:0]            rvfi_insn,
    input  logic [31:0]            rvfi_pc_rdata,
    input  logic [4:0]             rvfi_rd_addr,
    input  logic [31:0]            rvfi_rd_wdata,
    input  logic [31:0]            rvfi_mem_addr,
    input  logic [3:0]             rvfi_mem_rmask,
    input  logic [3:0]             rvfi_mem_wmask,
    input  logic                   trace_en,
    input  logic                   trace_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output trace_rec_t             out_record,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            drop_cnt,
    output logic                   overflow
);

    // Elaboration-time parameter legality.
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        MODE > MODE_OVERWRITE || TS_W < 1 || TS_W > TRACE_TS_W) begin : g_bad_param
        $error("rvfi_trace_buffer: illegal DEPTH, MODE or TS_W");
    end

    localparam logic OVERWRITE = (MODE == MODE_OVERWRITE);

    trace_state_t state;
    trace_rec_t   rec_c;
    logic         push_c;
    logic         pop_c;
    logic         drop_c;
    logic         wr_en_c;
    logic         rd_en_c;
    logic         full_c;

`ifdef RVFI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // Free-running wrapping cycle counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + TS_W'(1);
    end
`endif

    // Record assembly; x0 writes are architecturally zero.
    always_comb begin
        rec_c          = '0;
        rec_c.insn     = rvfi_insn;
        rec_c.pc       = rvfi_pc_rdata;
        rec_c.rd_addr  = rvfi_rd_addr;
        rec_c.rd_wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
        rec_c.mem_addr = rvfi_mem_addr;
        rec_c.rmask    = rvfi_mem_rmask;
        rec_c.wmask    = rvfi_mem_wmask;
`ifdef RVFI_TRACE_TIMESTAMP_EN
        rec_c.ts       = TRACE_TS_W'(ts_cnt);
`endif
    end

    // Full policy: a simultaneous pop makes room; otherwise drop or evict oldest.
    always_comb begin
        push_c  = (state == RUN) && rvfi_valid;
        pop_c   = out_valid && out_ready;
        drop_c  = push_c && full_c && !pop_c;
        wr_en_c = push_c && !(drop_c && !OVERWRITE);
        rd_en_c = pop_c || (drop_c && OVERWRITE);
    end

    rvfi_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (trace_clear),
        .wr_en   (wr_en_c),
        .wr_data (rec_c),
        .rd_en   (rd_en_c),
        .head_c  (out_record),
        .full_c  (full_c),
        .level   (level),
        .valid   (out_valid)
    );

    // Capture FSM plus drop accounting.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (trace_clear) begin
            state    <= IDLE;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (trace_en) state <= RUN;
                RUN:     if (!trace_en) state <= DRAIN;
                DRAIN: begin
                    if (trace_en)           state <= RUN;
                    else if (level == '0)   state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed scoreboard bench: one MODE 0 and one MODE 1 instance (DEPTH 4)
// share stimulus; expected records are queued as retires are driven.
module tb_rvfi_trace_buffer;
    import rvfi_trace_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rvfi_valid;
    logic [31:0] rvfi_insn;
    logic [31:0] rvfi_pc_rdata;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;
    logic        trace_en;
    logic        trace_clear;
    logic        out_ready;

    logic        out_valid0, out_valid1;
    trace_rec_t  out_record0, out_record1;
    logic [2:0]  level0, level1;
    logic [15:0] drop_cnt0, drop_cnt1;
    logic        overflow0, overflow1;

    int checks = 0;
    int errors = 0;

    trace_rec_t   q0[$];
    trace_rec_t   q1[$];
    int           d0, d1;
    logic         ov0, ov1;
    trace_state_t st;

    always #5 clk = ~clk;

    rvfi_trace_buffer #(.DEPTH(DEPTH), .MODE(MODE_DROP)) dut0 (
        .CLK(clk), .RESET(rst), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .trace_en(trace_en), .trace_clear(trace_clear), .out_valid(out_valid0),
        .out_ready(out_ready), .out_record(out_record0), .level(level0),
        .drop_cnt(drop_cnt0), .overflow(overflow0)
    );

    rvfi_trace_buffer #(.DEPTH(DEPTH), .MODE(MODE_OVERWRITE)) dut1 (
        .CLK(clk), .RESET(rst), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .trace_en(trace_en), .trace_clear(trace_clear), .out_valid(out_valid1),
        .out_ready(out_ready), .out_record(out_record1), .level(level1),
        .drop_cnt(drop_cnt1), .overflow(overflow1)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic trace_rec_t exp_rec();
        trace_rec_t r;
        r          = '0;
        r.insn     = rvfi_insn;
        r.pc       = rvfi_pc_rdata;
        r.rd_addr  = rvfi_rd_addr;
        r.rd_wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
        r.mem_addr = rvfi_mem_addr;
        r.rmask    = rvfi_mem_rmask;
        r.wmask    = rvfi_mem_wmask;
        return r;
    endfunction

    function automatic trace_rec_t head_of(input trace_rec_t q[$]);
        return (q.size() != 0) ? q[0] : trace_rec_t'('0);
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete();
        d0 = 0; d1 = 0; ov0 = 1'b0; ov1 = 1'b0;
        st = IDLE;
    endtask

    task automatic check_all(input string where);
        chk({where, " d0 level"},    160'(level0),      160'(q0.size()));
        chk({where, " d0 valid"},    160'(out_valid0),  160'(q0.size() != 0));
        chk({where, " d0 record"},   160'(out_record0), 160'(head_of(q0)));
        chk({where, " d0 drop_cnt"}, 160'(drop_cnt0),   160'(d0));
        chk({where, " d0 overflow"}, 160'(overflow0),   160'(ov0));
        chk({where, " d1 level"},    160'(level1),      160'(q1.size()));
        chk({where, " d1 valid"},    160'(out_valid1),  160'(q1.size() != 0));
        chk({where, " d1 record"},   160'(out_record1), 160'(head_of(q1)));
        chk({where, " d1 drop_cnt"}, 160'(drop_cnt1),   160'(d1));
        chk({where, " d1 overflow"}, 160'(overflow1),   160'(ov1));
    endtask

    // One clock: drive, update scoreboard, advance, check.
    task automatic step(input string where, input logic v, input logic rdy);
        int         pre_size;
        logic       cap;
        trace_rec_t r;
        rvfi_valid = v;
        out_ready  = rdy;
        pre_size   = q0.size();
        cap        = (st == RUN) && v;
        r          = exp_rec();
        if (trace_clear) begin
            model_reset();
        end else begin
            if (rdy && q0.size() != 0) begin
                chk({where, " d0 pop"}, 160'(out_record0), 160'(q0[0]));
                void'(q0.pop_front());
            end
            if (rdy && q1.size() != 0) begin
                chk({where, " d1 pop"}, 160'(out_record1), 160'(q1[0]));
                void'(q1.pop_front());
            end
            if (cap) begin
                if (q0.size() == DEPTH) begin
                    d0++; ov0 = 1'b1;
                end else begin
                    q0.push_back(r);
                end
                if (q1.size() == DEPTH) begin
                    d1++; ov1 = 1'b1;
                    void'(q1.pop_front());
                end
                q1.push_back(r);
            end
            case (st)
                IDLE:    if (trace_en) st = RUN;
                RUN:     if (!trace_en) st = DRAIN;
                default: if (trace_en) st = RUN; else if (pre_size == 0) st = IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        rvfi_valid  = 1'b0;
        out_ready   = 1'b0;
        trace_clear = 1'b0;
        check_all(where);
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic [31:0] insn,
                           input logic [4:0] rd, input logic [31:0] wdata);
        rvfi_pc_rdata  = pc;
        rvfi_insn      = insn;
        rvfi_rd_addr   = rd;
        rvfi_rd_wdata  = wdata;
        rvfi_mem_addr  = pc + 32'h1000;
        rvfi_mem_rmask = pc[5:2];
        rvfi_mem_wmask = ~pc[5:2];
    endtask

    initial begin
        rst = 1'b1; rvfi_valid = 1'b0; out_ready = 1'b0;
        trace_en = 1'b0; trace_clear = 1'b0;
        set_rec(32'h0, 32'h0, 5'd0, 32'h0);
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        step("idle", 1'b0, 1'b0);

        // Enable with a retire in the transition cycle: must not be captured.
        trace_en = 1'b1;
        set_rec(32'h40, 32'h00000013, 5'd2, 32'h11);
        step("enable", 1'b1, 1'b0);

        // Single retire appears one cycle later.
        set_rec(32'h80, 32'h00500093, 5'd1, 32'h5);
        step("first", 1'b1, 1'b0);
        chk("first pc",      160'(out_record0.pc),      160'(32'h80));
        chk("first rd_addr", 160'(out_record0.rd_addr), 160'(5'd1));
        step("pop1", 1'b0, 1'b1);

        // x0 destination stores zero write data.
        set_rec(32'h84, 32'h00000013, 5'd0, 32'hDEAD_BEEF);
        step("x0", 1'b1, 1'b0);
        step("pop_x0", 1'b0, 1'b1);

        // Six retires into a four-entry FIFO with the sink stalled.
        for (int i = 0; i < 6; i++) begin
            set_rec(32'h100 + 32'(i * 4), 32'h1000_0000 + 32'(i), 5'(i + 3), 32'(i * 7));
            step($sformatf("fill%0d", i), 1'b1, 1'b0);
        end
        chk("mode0 head pc", 160'(out_record0.pc), 160'(32'h100));
        chk("mode1 head pc", 160'(out_record1.pc), 160'(32'h108));

        // Full with simultaneous push and pop: no drop, level unchanged.
        set_rec(32'h200, 32'h2000_0000, 5'd9, 32'h99);
        step("full_pushpop", 1'b1, 1'b1);

        // Clear has priority over the concurrent push and pop.
        trace_clear = 1'b1;
        set_rec(32'h204, 32'h2000_0001, 5'd9, 32'h98);
        step("clear", 1'b1, 1'b1);

        // Back to RUN, queue three, then drain with retires that must be ignored.
        step("rerun", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_rec(32'h300 + 32'(i * 4), 32'h3000_0000 + 32'(i), 5'(i + 1), 32'(i + 100));
            step($sformatf("q%0d", i), 1'b1, 1'b0);
        end
        trace_en = 1'b0;
        step("to_drain", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_rec(32'h400 + 32'(i * 4), 32'h4000_0000, 5'd4, 32'h4);
            step($sformatf("drain%0d", i), 1'b1, 1'b1);
        end
        step("to_idle", 1'b1, 1'b0);
        step("idle_ignore", 1'b1, 1'b0);

        // Reset pulse with two queued records.
        trace_en = 1'b1;
        step("run_again", 1'b0, 1'b0);
        set_rec(32'h500, 32'h5000_0000, 5'd5, 32'h55);
        step("pre_rst0", 1'b1, 1'b0);
        set_rec(32'h504, 32'h5000_0001, 5'd6, 32'h66);
        step("pre_rst1", 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        trace_en = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst0", 1'b0, 1'b1);
        step("post_rst1", 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_trace_buffer.md
RVFI_TRACE_BUFFER -- requirements
Module: rvfi_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; legal values are powers of two, 2..256.
REQ-002 SHALL have parameter MODE, default 0, meaning full policy: 0 drops new records, 1 overwrites the oldest record.
REQ-003 SHALL have parameter TS_W, default 32, meaning timestamp width; used only with REQ-030.
REQ-004 SHALL have ports, clock and reset first:
  CLK             in   1         clock, rising edge
  RESET           in   1         asynchronous, active-high reset
  rvfi_valid      in   1         retirement strobe
  rvfi_insn       in   32        retired instruction
  rvfi_pc_rdata   in   32        retired PC
  rvfi_rd_addr    in   5         destination register
  rvfi_rd_wdata   in   32        destination write data
  rvfi_mem_addr   in   32        memory address
  rvfi_mem_rmask  in   4         read byte mask
  rvfi_mem_wmask  in   4         write byte mask
  trace_en        in   1         capture enable
  trace_clear     in   1         synchronous flush of all state
  out_valid       out  1         head record available
  out_ready       in   1         sink accepts head record
  out_record      out  trace_rec_t  head record
  level           out  $clog2(DEPTH)+1  current occupancy
  drop_cnt        out  16        dropped-record count, saturating
  overflow        out  1         sticky; set on first drop

Function
REQ-005 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-006 SHALL move IDLE->RUN when trace_en=1, RUN->DRAIN when trace_en=0, DRAIN->IDLE when empty, and DRAIN->RUN when trace_en=1.
REQ-007 SHALL capture a record only when in RUN and rvfi_valid=1; capture in the cycle of the RUN transition is excluded.
REQ-008 SHALL present a record captured at edge N on out_record/out_valid after edge N when the FIFO was empty, i.e. 1-cycle latency.
REQ-009 SHALL assert out_valid exactly when level!=0; pop occurs on out_valid&&out_ready.
REQ-010 SHALL hold out_record stable while out_valid=1 and out_ready=0.
REQ-011 SHALL store rd_wdata as 0 when rvfi_rd_addr=0.
REQ-012 SHALL, when full with simultaneous push and pop, accept both in both modes; level is unchanged and nothing is dropped.
REQ-013 SHALL, in MODE 0, when full with push and no pop, discard the new record, increment drop_cnt and set overflow.
REQ-014 SHALL, in MODE 1, when full with push and no pop, write the new record, advance the read pointer, increment drop_cnt and set overflow.
REQ-015 SHALL, when empty with push and pop in the same cycle, not pop; out_valid rises on the next cycle.
REQ-016 SHALL wrap read and write pointers modulo DEPTH and use an extra wrap bit to distinguish full from empty.
REQ-017 SHALL saturate drop_cnt at 16'hFFFF.
REQ-018 SHALL, on trace_clear=1, empty the FIFO, zero drop_cnt, clear overflow and enter IDLE at the next edge; trace_clear has priority over push and pop.

Reset
REQ-019 SHALL, while RESET=1, force immediately: state IDLE, pointers 0, level=0, out_valid=0, drop_cnt=0, overflow=0, out_record=0.
REQ-020 SHALL discard any record in flight when reset is asserted mid-operation, and SHALL NOT emit any record in the first cycle after release.

Configuration
REQ-030 SHALL, with RVFI_TRACE_TIMESTAMP_EN defined, run a TS_W-bit wrapping cycle counter (reset 0) and store its capture-cycle value in field ts of each record.
REQ-031 SHALL, without RVFI_TRACE_TIMESTAMP_EN, omit the counter and the ts field; the record is then 141 bits.

Structure
REQ-040 SHALL define trace_rec_t as a packed struct in package rvfi_trace_pkg, with fields insn, pc, rd_addr, rd_wdata, mem_addr, rmask, wmask and ts (ts under the macro).
REQ-041 SHALL define the FSM state enum and the MODE_DROP/MODE_OVERWRITE constants in rvfi_trace_pkg.
REQ-042 SHALL place storage in one sub-module, rvfi_trace_fifo; the FSM and counters stay in the top module.

Verification
REQ-050 SHALL cover: trace_en=1, one retire with pc=0x80 and insn=0x00500093 -> out_valid=1 next cycle, record pc=0x80, rd_addr=1.
REQ-051 SHALL cover: DEPTH=4, MODE=0, 6 retires with out_ready=0 -> level=4, drop_cnt=2, overflow=1, head=first record.
REQ-052 SHALL cover: DEPTH=4, MODE=1, 6 retires with out_ready=0 -> level=4, head=3rd record, drop_cnt=2.
REQ-053 SHALL cover: full FIFO, push and pop in the same cycle -> level stays 4, drop_cnt unchanged.
REQ-054 SHALL cover: trace_en falls with 3 queued records -> DRAIN; 3 pops -> IDLE; retires during DRAIN are ignored.
REQ-055 SHALL cover: RESET pulse with 2 queued records -> out_valid=0 and level=0 immediately, with no emission after release.
